// File: rtl/data_cache.sv
`default_nettype none
// ============================================================================
// data_cache : direct-mapped write-back / write-allocate data cache
// Rev 1.0
// ============================================================================
module data_cache #(
   parameter int LINE_NUM   = 64,
   parameter int INDEX_BITS = 6,
   parameter int TAG_BITS   = 22
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cpu_ren,
   input  logic          cpu_wen,
   input  logic [31:0]   cpu_addr,
   input  logic [31:0]   cpu_din,
   output logic [31:0]   cpu_dout,
   output logic          cpu_stall,
   output logic          ram_cs,
   output logic          ram_we,
   output logic [31:0]   ram_addr,
   output logic [127:0]  ram_dout,
   input  logic [127:0]  ram_din,
   input  logic          ram_ack,
   output logic [31:0]   hit_count,
   output logic [31:0]   miss_count
);

   localparam logic [1:0] S_IDLE      = 2'd0;
   localparam logic [1:0] S_WRITEBACK = 2'd1;
   localparam logic [1:0] S_REFILL    = 2'd2;

   logic [1:0]            r_state;
   logic [1:0]            w_next_state;

   logic [LINE_NUM-1:0]   r_valid;
   logic [LINE_NUM-1:0]   r_dirty;
   logic [TAG_BITS-1:0]   r_tag  [LINE_NUM];
   logic [127:0]          r_data [LINE_NUM];

   logic [TAG_BITS-1:0]   r_miss_tag;
   logic [INDEX_BITS-1:0] r_miss_index;
   logic [31:0]           r_hit_count;
   logic [31:0]           r_miss_count;

   logic [TAG_BITS-1:0]   w_tag;
   logic [INDEX_BITS-1:0] w_index;
   logic [1:0]            w_word;
   logic                  w_req;
   logic                  w_hit;
   logic                  w_idle_hit;
   logic                  w_idle_miss;
   logic                  w_fill;
   logic [127:0]          w_line;
   logic                  w_unused_addr;

   assign w_tag         = cpu_addr[31 -: TAG_BITS];
   assign w_index       = cpu_addr[4 +: INDEX_BITS];
   assign w_word        = cpu_addr[3:2];
   assign w_unused_addr = &{1'b0, cpu_addr[1:0]};

   assign w_req       = cpu_ren | cpu_wen;
   assign w_hit       = r_valid[w_index] && (r_tag[w_index] == w_tag);
   assign w_line      = r_data[w_index];
   assign w_idle_hit  = (r_state == S_IDLE) && w_req && w_hit;
   assign w_idle_miss = (r_state == S_IDLE) && w_req && !w_hit;
   assign w_fill      = (r_state == S_REFILL) && ram_ack;

   assign hit_count  = r_hit_count;
   assign miss_count = r_miss_count;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_idle_miss) begin
               w_next_state = (r_valid[w_index] && r_dirty[w_index]) ? S_WRITEBACK : S_REFILL;
            end
         end
         S_WRITEBACK: begin
            if (ram_ack) w_next_state = S_REFILL;
         end
         S_REFILL: begin
            if (ram_ack) w_next_state = S_IDLE;
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   // Memory-side outputs use the latched miss address so a withdrawn request
   // cannot disturb an in-flight transaction.
   always_comb begin
      cpu_stall = 1'b0;
      cpu_dout  = 32'd0;
      ram_cs    = 1'b0;
      ram_we    = 1'b0;
      ram_addr  = 32'd0;
      ram_dout  = 128'd0;
      if (!rst) begin
         case (r_state)
            S_IDLE: begin
               cpu_stall = w_idle_miss;
               if (w_idle_hit && !cpu_wen) begin
                  cpu_dout = w_line[{w_word, 5'b00000} +: 32];
               end
            end
            S_WRITEBACK: begin
               cpu_stall = 1'b1;
               ram_cs    = 1'b1;
               ram_we    = 1'b1;
               ram_addr  = {r_tag[r_miss_index], r_miss_index, 4'b0000};
               ram_dout  = r_data[r_miss_index];
            end
            S_REFILL: begin
               cpu_stall = 1'b1;
               ram_cs    = 1'b1;
               ram_addr  = {r_miss_tag, r_miss_index, 4'b0000};
            end
            default: cpu_stall = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid      <= '0;
         r_dirty      <= '0;
         r_hit_count  <= 32'd0;
         r_miss_count <= 32'd0;
         r_miss_tag   <= '0;
         r_miss_index <= '0;
      end else begin
         if (w_idle_hit) begin
            r_hit_count <= r_hit_count + 32'd1;
            if (cpu_wen) r_dirty[w_index] <= 1'b1;
         end
         if (w_idle_miss) begin
            r_miss_count <= r_miss_count + 32'd1;
            r_miss_tag   <= w_tag;
            r_miss_index <= w_index;
         end
         if (w_fill) begin
            r_valid[r_miss_index] <= 1'b1;
            r_dirty[r_miss_index] <= 1'b0;
         end
      end
   end

   // Tag and data arrays carry no reset; the valid bits qualify them.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (w_idle_hit && cpu_wen) begin
            r_data[w_index][{w_word, 5'b00000} +: 32] <= cpu_din;
         end
         if (w_fill) begin
            r_data[r_miss_index] <= ram_din;
            r_tag[r_miss_index]  <= r_miss_tag;
         end
      end
   end

endmodule
`default_nettype wire
